// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters sharing one decoded resource.
// Registered one-hot grant, encoded select index, and a bounded hold counter that forces rotation.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [3:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] win;
  logic       own_req;
  logic       others;

  // Scan ptr+4 down to ptr+1 so the last hit is the first set bit after ptr.
  always_comb begin
    win = ptr_q;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  assign own_req = req[ptr_q];
  assign others  = |(req & ~(4'b0001 << ptr_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          ptr_d   = win;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (!own_req) begin
          hold_d = 4'd0;
          if (others) ptr_d = win;
          else        state_d = IDLE;
        end else if (hold_q == HOLD_LAST && others) begin
          ptr_d  = win;
          hold_d = 4'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; idle forces everything to zero.
  always_comb begin
    gnt       = 4'b0000;
    gnt_idx   = 2'b00;
    gnt_valid = 1'b0;
    hold_cnt  = hold_q;
    if (state_q == GRANT) begin
      gnt       = 4'b0001 << ptr_q;
      gnt_idx   = ptr_q;
      gnt_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, pickup, handover, preemption, saturation, mid-grant reset.
// A second instance with MAX_HOLD=1 is checked for per-cycle rotation under contention.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt, gnt1;
  logic [1:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1;
  logic [3:0] hold_cnt, hold_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt)
  );

  rr_arbiter_4 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .hold_cnt(hold_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                         input logic e_vld, input logic [3:0] e_hold);
    chk({tag, ".gnt"},   gnt,               e_gnt);
    chk({tag, ".idx"},   {2'b00, gnt_idx},  {2'b00, e_idx});
    chk({tag, ".valid"}, {3'b000, gnt_valid}, {3'b000, e_vld});
    chk({tag, ".hold"},  hold_cnt,          e_hold);
  endtask

  function automatic logic [3:0] oh(input int k);
    logic [3:0] v;
    v = 4'b0001 << k;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;

    // Reset held two edges with everyone requesting
    tick(); tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 4'b0001, 2'd0, 1'b1, 4'd0);

    // Idle pickup from ptr=3
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0110; tick();
    chk_all("pickup", 4'b0010, 2'd1, 1'b1, 4'd0);
    req = 4'b0000; tick();
    chk_all("idle", 4'b0000, 2'd0, 1'b0, 4'd0);

    // No-bubble handover from owner 0 to 2
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0101; tick();
    chk_all("ho_owner0", 4'b0001, 2'd0, 1'b1, 4'd0);
    req = 4'b0100; tick();
    chk_all("handover", 4'b0100, 2'd2, 1'b1, 4'd0);

    // Full contention: 8-cycle slots in order 0,1,2,3,0; MAX_HOLD=1 rotates every cycle
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk_all($sformatf("rot%0d", c), oh((c / 8) % 4), 2'((c / 8) % 4), 1'b1, 4'(c % 8));
      chk($sformatf("mh1_gnt%0d", c), gnt1, oh(c % 4));
      chk($sformatf("mh1_hold%0d", c), hold_cnt1, 4'd0);
    end

    // Lone requester 3 after owner 0 releases; hold saturates at 7
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_all($sformatf("lone%0d", c), 4'b1000, 2'd3, 1'b1, (c < 7) ? 4'(c) : 4'd7);
    end
    req = 4'b1001; tick();
    chk_all("lone_preempt", 4'b0001, 2'd0, 1'b1, 4'd0);

    // Reset mid-grant with owner 2 at hold 5
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0100; tick();
    repeat (5) tick();
    chk_all("mid_pre", 4'b0100, 2'd2, 1'b1, 4'd5);
    rst_n = 1'b0; tick();
    chk_all("mid_rst", 4'b0000, 2'd0, 1'b0, 4'd0);
    rst_n = 1'b1; tick();
    chk_all("mid_post", 4'b0100, 2'd2, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
